// File: rtl/mash111_core.sv
// mash111_core: third-order MASH 1-1-1 noise shaper producing a 4-bit signed fractional correction per enabled clock.
// Three pipelined accumulators feed carry delay lines that align the stages before error cancellation.
module mash111_core #(
  parameter int          P_ACC_WIDTH = 16,
  parameter logic [14:0] P_LFSR_SEED = 15'h0001
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic                   i_load,
  input  logic [P_ACC_WIDTH-1:0] i_frac_word,
  input  logic                   i_dither_en,
  output logic [3:0]             o_frac,
  output logic                   o_valid
);
  localparam int W = P_ACC_WIDTH;
  logic [W-1:0] r_act, r_s1, r_s2, r_s3;
  logic         r_c1, r_c2, r_c3;
  logic         r_c1_d1, r_c1_d2, r_c2_d1, r_c2_d2, r_c3_d1, r_c3_d2;
  logic [14:0]  r_lfsr;
  logic [1:0]   r_cnt;
  logic [3:0]   r_frac;
  logic         r_valid;
  logic         w_d;
  logic [W:0]   w_sum1, w_sum2, w_sum3;
  logic [3:0]   w_y;
  assign w_d    = r_lfsr[0] & i_dither_en;
  assign w_sum1 = {1'b0, r_s1} + {1'b0, r_act} + {{W{1'b0}}, w_d};
  assign w_sum2 = {1'b0, r_s2} + {1'b0, r_s1};
  assign w_sum3 = {1'b0, r_s3} + {1'b0, r_s2};
  // 4-bit modular arithmetic yields the correct two's-complement result for -3..+4
  assign w_y = 4'(r_c1_d2) + 4'(r_c2_d1) - 4'(r_c2_d2)
             + 4'(r_c3) - {2'b00, r_c3_d1, 1'b0} + 4'(r_c3_d2);
  assign o_frac  = r_frac;
  assign o_valid = r_valid;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_act <= '0;
    else if (i_load) r_act <= i_frac_word;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || i_clr) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      {r_c1, r_c2, r_c3} <= '0;
      {r_c1_d1, r_c1_d2, r_c2_d1, r_c2_d2, r_c3_d1, r_c3_d2} <= '0;
      r_lfsr  <= P_LFSR_SEED;
      r_cnt   <= '0;
      r_frac  <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      {r_c1, r_s1} <= w_sum1;
      {r_c2, r_s2} <= w_sum2;
      {r_c3, r_s3} <= w_sum3;
      {r_c1_d2, r_c1_d1} <= {r_c1_d1, r_c1};
      {r_c2_d2, r_c2_d1} <= {r_c2_d1, r_c2};
      {r_c3_d2, r_c3_d1} <= {r_c3_d1, r_c3};
      r_lfsr  <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
      r_cnt   <= r_cnt + {1'b0, r_cnt != 2'd3};
      r_frac  <= w_y;
      r_valid <= r_valid | (r_cnt == 2'd3);
    end
  end
endmodule

// File: tb/tb_mash111_core.sv
// tb_mash111_core: randomized and directed checks of mash111_core against an arithmetic reference model.
module tb_mash111_core;
  localparam int M = 65536;
  logic        i_clk = 0, i_rst_n = 0, i_en = 0, i_clr = 0, i_load = 0, i_dither_en = 0;
  logic [15:0] i_frac_word = 0;
  logic [3:0]  o_frac;
  logic        o_valid;
  int n_tests = 0, n_fail = 0;
  int m_act, m_s1, m_s2, m_s3, m_frac, m_valid, m_edges, m_lfsr;
  int c1h[3], c2h[3], c3h[3];
  mash111_core #(.P_ACC_WIDTH(16), .P_LFSR_SEED(15'h0001)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_clr(i_clr), .i_load(i_load),
    .i_frac_word(i_frac_word), .i_dither_en(i_dither_en), .o_frac(o_frac), .o_valid(o_valid)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic m_clear();
    {m_s1, m_s2, m_s3, m_frac, m_valid, m_edges} = '0;
    m_lfsr = 1;
    for (int i = 0; i < 3; i++) begin
      c1h[i] = 0; c2h[i] = 0; c3h[i] = 0;
    end
  endtask
  // carry histories: index 0 = latest carry, 1 = one enabled edge older, 2 = two older
  task automatic m_step();
    int y, nact, d, t1, t2, t3;
    y = c1h[2] + c2h[1] - c2h[2] + c3h[0] - 2 * c3h[1] + c3h[2];
    nact = i_load ? int'(i_frac_word) : m_act;
    if (i_clr) m_clear();
    else if (i_en) begin
      d  = (m_lfsr & 1) & int'(i_dither_en);
      t1 = m_s1 + m_act + d;
      t2 = m_s2 + m_s1;
      t3 = m_s3 + m_s2;
      for (int i = 2; i > 0; i--) begin
        c1h[i] = c1h[i-1]; c2h[i] = c2h[i-1]; c3h[i] = c3h[i-1];
      end
      c1h[0] = int'(t1 >= M); c2h[0] = int'(t2 >= M); c3h[0] = int'(t3 >= M);
      m_s1 = t1 % M; m_s2 = t2 % M; m_s3 = t3 % M;
      m_frac = y;
      m_edges++;
      m_valid = int'(m_edges >= 4);
      m_lfsr = ((m_lfsr << 1) & 'h7fff) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1);
    end
    m_act = nact;
  endtask
  task automatic tick(input string tag);
    @(posedge i_clk);
    m_step();
    #1;
    chk({tag, "_frac"}, int'($signed(o_frac)), m_frac);
    chk({tag, "_valid"}, int'(o_valid), m_valid);
  endtask
  task automatic load(input int w);
    i_load = 1; i_frac_word = 16'(w);
    tick("load");
    i_load = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int sum, bad, nz, f;
    m_clear(); m_act = 0;
    #12;
    chk("rst_frac", int'(o_frac), 0);
    chk("rst_valid", int'(o_valid), 0);
    i_rst_n = 1; i_en = 1;
    for (int i = 0; i < 8; i++) begin
      tick("zero");
      chk("zero_out", int'(o_frac), 0);
      if (i == 2) chk("valid_edge3", int'(o_valid), 0);
      if (i == 3) chk("valid_edge4", int'(o_valid), 1);
    end
    load('h8000);
    for (int i = 0; i < 8; i++) tick("half_fill");
    sum = 0; bad = 0;
    for (int i = 0; i < 4096; i++) begin
      tick("half");
      f = int'($signed(o_frac)); sum += f;
      if (f < -3 || f > 4) bad++;
    end
    chk("half_sum_in_2048pm3", int'(sum >= 2045 && sum <= 2051), 1);
    chk("half_range", bad, 0);
    load(1);
    for (int i = 0; i < 8; i++) tick("fine_fill");
    sum = 0; bad = 0;
    for (int i = 0; i < 65536; i++) begin
      tick("fine");
      f = int'($signed(o_frac)); sum += f;
      if (f < -3 || f > 4) bad++;
    end
    chk("fine_sum_in_1pm3", int'(sum >= -2 && sum <= 4), 1);
    chk("fine_range", bad, 0);
    i_clr = 1; load(0); i_clr = 0;
    for (int i = 0; i < 6; i++) tick("lat_fill");
    load('hFFFF);
    for (int i = 0; i < 2; i++) begin
      tick("lat");
      chk("lat_early_zero", int'(o_frac), 0);
    end
    for (int i = 0; i < 20; i++) tick("lat_run");
    i_en = 0;
    for (int i = 0; i < 10; i++) tick("hold");
    i_en = 1;
    for (int i = 0; i < 20; i++) tick("resume");
    i_clr = 1;
    tick("clr");
    chk("clr_frac", int'(o_frac), 0);
    chk("clr_valid", int'(o_valid), 0);
    i_clr = 0;
    for (int i = 0; i < 12; i++) tick("clr_keep_act");
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) i_dither_en = 1'($urandom_range(0, 1));
      i_en = ($urandom_range(0, 9) < 8);
      i_clr = ($urandom_range(0, 99) == 0);
      i_load = ($urandom_range(0, 29) == 0);
      i_frac_word = 16'($urandom);
      tick("rand");
    end
    i_load = 0; i_clr = 1; i_en = 1; i_dither_en = 1;
    load(0);
    i_clr = 0; nz = 0;
    for (int i = 0; i < 8000; i++) begin
      tick("dither");
      if (o_frac != 0) nz++;
    end
    chk("dither_nonzero", int'(nz > 0), 1);
    i_dither_en = 0;
    #3 i_rst_n = 0;
    #1;
    chk("async_rst_frac", int'(o_frac), 0);
    chk("async_rst_valid", int'(o_valid), 0);
    m_clear(); m_act = 0;
    #2 i_rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick("post_rst");
      chk("post_rst_zero", int'(o_frac), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
